// File: rtl/dp_pkg.sv
// Shared types and constants for the SMAC output drain path.
// The drain walks NUM_GROUPS mux groups and counts the words popped.
package dp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  localparam int NUM_GROUPS = 4;
  localparam int GRP_W      = 2;
  localparam int POP_W      = 3;

endpackage

// File: rtl/dp_drain_fifo.sv
// Small synchronous FIFO between the data path output register and the stream port.
// A push and a pop in the same cycle are allowed at any occupancy, including full.
module dp_drain_fifo #(
  parameter int BW    = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [BW-1:0]              wdata,
  input  logic                       pop,
  output logic [BW-1:0]              rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == CNT_MAX);
  // Head is forced to zero while empty so the stream data is clean out of reset.
  assign rdata  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));
`endif

endmodule

// File: rtl/dp_out_drain.sv
// Output drain sequencer: steps the data path output mux through the four groups,
// pulses write-back, and streams the captured words out through a credit-managed FIFO.
module dp_out_drain
  import dp_pkg::*;
#(
  parameter int BW    = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [GRP_W-1:0] sel_mux_out,
  output logic             wb,
  input  logic [BW-1:0]    dp_out_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BW-1:0]    m_data,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]      CREDIT_MAX = (CW + 1)'(DEPTH);
  localparam logic [GRP_W-1:0] GRP_ONE    = GRP_W'(1);
  localparam logic [GRP_W-1:0] GRP_LAST   = GRP_W'(NUM_GROUPS - 1);
  localparam logic [POP_W-1:0] POP_ONE    = POP_W'(1);
  localparam logic [POP_W-1:0] POP_LAST   = POP_W'(NUM_GROUPS - 1);

  drain_state_t     state;
  drain_state_t     state_nxt;
  logic [GRP_W-1:0] grp;
  logic [GRP_W-1:0] grp_nxt;
  logic [GRP_W-1:0] sel_q;
  logic [POP_W-1:0] pop_cnt;
  logic [POP_W-1:0] pop_cnt_nxt;
  logic             wb_p1;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             credit;

  // A word whose write-back was issued last cycle is still in flight and owns a slot.
  assign credit      = ({1'b0, fifo_count} + {{CW{1'b0}}, wb_p1}) < CREDIT_MAX;
  assign m_valid     = !fifo_empty;
  assign pop         = m_valid && m_ready;
  assign busy        = (state != IDLE);
  assign sel_mux_out = wb ? grp : sel_q;

  always_comb begin
    state_nxt   = state;
    grp_nxt     = grp;
    pop_cnt_nxt = pop_cnt;
    wb          = 1'b0;
    done        = 1'b0;
    if (pop) pop_cnt_nxt = pop_cnt + POP_ONE;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = ISSUE;
          grp_nxt     = '0;
          pop_cnt_nxt = '0;
        end
      end
      ISSUE: begin
        if (credit) begin
          wb      = 1'b1;
          grp_nxt = grp + GRP_ONE;
          if (grp == GRP_LAST) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (pop_cnt == POP_LAST)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: write-back issued, data path output register loads next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grp     <= '0;
      pop_cnt <= '0;
      sel_q   <= '0;
      wb_p1   <= 1'b0;
    end else begin
      state   <= state_nxt;
      grp     <= grp_nxt;
      pop_cnt <= pop_cnt_nxt;
      sel_q   <= sel_mux_out;
      wb_p1   <= wb;
    end
  end

  // Stage p1: registered data path word is captured into the FIFO
  dp_drain_fifo #(
    .BW    (BW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wb_p1),
    .wdata (dp_out_data),
    .pop   (pop),
    .rdata (m_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

`ifndef SYNTHESIS
  a_issue_not_full: assert property (@(posedge clk) disable iff (!rst_n)
    wb |-> !fifo_full);
`endif

endmodule

// File: doc/dp_out_drain.md
# dp_out_drain

Output drain sequencer for the 1x64 SMAC data path. After a layer's results are ready it steps the data path's 4:1 output mux through the four 16-SMAC groups, pulses the output-register write-back, and captures each registered BW-bit word into a small FIFO. The FIFO is presented to the memory side as a valid/ready stream with full back-pressure support. The block sits directly downstream of the data path and drives that path's `sel_mux_out` and `wb` inputs.

## Interface
- `BW`, 128: data word width; equals the data path `BW`.
- `DEPTH`, 4: FIFO depth in words; power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `start` input 1: one-cycle request to drain the four groups; ignored unless the FSM is in IDLE.
- `sel_mux_out` output 2: group select to the data path mux.
- `wb` output 1: write enable of the data path output register.
- `dp_out_data` input BW: data path registered output.
- `m_valid` output 1: stream word valid.
- `m_ready` input 1: stream consumer ready.
- `m_data` output BW: stream word, equal to the FIFO head.
- `busy` output 1: high while a drain is in progress.
- `done` output 1: one-cycle pulse after the 4th word is accepted.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on `start`.
  - `grp` counter (2 bits) cleared to 0.
  - Popped-word counter (3 bits) cleared to 0.
- ISSUE: each cycle with credit available, assert `wb`=1 with `sel_mux_out`=`grp`, then increment `grp`.
  - Credit rule: `fifo_count` + `inflight` < `DEPTH`, where `inflight` = `wb` of the previous cycle.
  - With no credit, `wb`=0 and `grp` holds.
  - After issuing `grp`=3, go to DRAIN.
- Capture: `wb_d` is `wb` delayed one cycle. When `wb_d`=1, push `dp_out_data` into the FIFO that cycle.
- FIFO:
  - `m_valid` = !empty; `m_data` = head.
  - Pop on `m_valid` && `m_ready`.
  - Simultaneous push and pop are legal at any occupancy, including full, where count stays constant.
  - Overflow is impossible by the credit rule.
  - Push into a full FIFO without a simultaneous pop is an assertion failure.
- DRAIN → DONE when the 4th pop occurs (popped-word counter reaches 4).
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy` = state != IDLE.
- `start` in any state other than IDLE is dropped, with no queueing.
- `sel_mux_out` holds its last value when `wb`=0 and resets to 0.

## Timing
- Reset values: `sel_mux_out`=0, `wb`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0; FIFO empty; state IDLE.
- Reset asserted mid-drain:
  - All state and FIFO pointers clear immediately.
  - Words not yet popped are lost.
  - No `done` is produced.
- `start` sampled at edge E0. All cycles below are counted from E0:
  - `busy`=1 from cycle 1.
  - `wb` in cycles 1–4 with `sel_mux_out` 0,1,2,3, provided credit is available.
  - FIFO pushes in cycles 2–5.
  - First `m_valid`=1 in cycle 3, because the FIFO write is registered.
- With `m_ready` held at 1:
  - Pops in cycles 3–6.
  - `done` and the DONE state in cycle 7; `busy`=0 from cycle 8.
  - Minimum drain = 8 cycles from `start` to idle.
- `m_data` and `m_valid` must stay stable while `m_valid`=1 and `m_ready`=0.
- Throughput: one word per cycle when `m_ready`=1. Issue stalls only when `fifo_count`+`inflight` = `DEPTH`.

## Structure
- Shared package `dp_pkg`:
  - `drain_state_t` enum (IDLE, ISSUE, DRAIN, DONE).
  - `localparam NUM_GROUPS = 4`.
  - `GRP_W = 2`.
- Sub-module `dp_drain_fifo`:
  - Parameters `BW` and `DEPTH`.
  - Synchronous FIFO: registered memory, read and write pointers, count.
  - Outputs `empty`, `full`, `count`.
- Top level holds the FSM, the `grp` and pop counters, the `wb_d` flop and the credit logic.

## Test plan
- Reset, `start` pulse, `m_ready`=1; model returns words A0..A3 for `sel_mux_out` 0..3 one cycle after `wb`:
  - `wb` in cycles 1–4.
  - `m_data` A0,A1,A2,A3 in cycles 3–6.
  - `done` in cycle 7 only.
- `m_ready`=0 for 20 cycles after `start`, `DEPTH`=4:
  - Exactly four `wb` pulses.
  - FIFO full and `m_data`=A0 held stable.
  - Release `m_ready` → four pops in order, then `done`.
- `DEPTH`=2, `m_ready`=0 until cycle 10:
  - Only two `wb` pulses before cycle 10.
  - Remaining two issued after pops free credit.
  - No overflow; order A0..A3.
- `m_ready` toggling 1,0,1,0 with a second `start` in cycle 5:
  - Second `start` ignored.
  - Exactly four handshakes; one `done`.
- `rst_n` asserted low in cycle 4 mid-drain:
  - All outputs at reset values immediately.
  - No `done`; a subsequent `start` yields a clean 8-cycle drain.
